// File: rtl/iommu_ds_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : iommu_ds_rd_arbiter
// Brief   : Round-robin AR arbiter with ID-tagged R routing and a per-requester
//           limit on outstanding read bursts.
// Revision: 1.0 - initial release
// ============================================================================
module iommu_ds_rd_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_OUTST  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*8-1:0]          req_len_i,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [ADDR_WIDTH-1:0]       ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [ID_WIDTH-1:0]         ar_id_o,
    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [ID_WIDTH-1:0]         r_id_i,
    input  logic [DATA_WIDTH-1:0]       r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    output logic [N_REQ-1:0]            rsp_valid_o,
    input  logic [N_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]       rsp_data_o,
    output logic                        rsp_err_o,
    output logic                        rsp_last_o,
    output logic                        bad_id_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_grant = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_gnt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W:0]        w_sum;
    logic                  w_found;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [CNT_W-1:0]      r_cnt [N_REQ];
    logic [N_REQ-1:0]      w_elig;
    logic [N_REQ-1:0]      w_inc;
    logic [N_REQ-1:0]      w_dec;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [ID_WIDTH:0]     w_rid_ext;
    logic                  w_rid_ok;
    logic [IDX_W-1:0]      w_rid_idx;
    logic                  r_bad_id;

    assign w_ar_hs   = (r_state == c_grant) && ar_ready_i;
    assign w_rid_ext = {1'b0, r_id_i};
    assign w_rid_ok  = (w_rid_ext < (ID_WIDTH + 1)'(N_REQ));
    assign w_rid_idx = r_id_i[IDX_W-1:0];
    assign w_r_hs    = r_valid_i && r_ready_o;

    // Search starts at the round-robin pointer and wraps at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(N_REQ);
            end
            if (!w_found && w_elig[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_found)    w_state_nxt = c_grant;
            c_grant: if (ar_ready_i) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        ar_valid_o  = (r_state == c_grant);
        req_ready_o = '0;
        if (w_ar_hs) begin
            req_ready_o[r_gnt] = 1'b1;
        end
        rsp_valid_o = '0;
        if (w_rid_ok) begin
            rsp_valid_o[w_rid_idx] = r_valid_i;
        end
        // Beats with an unknown ID are drained so the read channel never stalls.
        r_ready_o = w_rid_ok ? rsp_ready_i[w_rid_idx] : 1'b1;
    end

    // Burst fields are frozen at grant so AR stays stable while it waits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gnt    <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_rr_ptr <= '0;
        end else begin
            if ((r_state == c_idle) && w_found) begin
                r_gnt  <= w_pick;
                r_addr <= req_addr_i[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                r_len  <= req_len_i[w_pick*8 +: 8];
            end
            if (w_ar_hs) begin
                r_rr_ptr <= (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + IDX_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        assign w_elig[i] = req_valid_i[i] && (r_cnt[i] < CNT_W'(MAX_OUTST));
        assign w_inc[i]  = w_ar_hs && (r_gnt == IDX_W'(i));
        assign w_dec[i]  = w_r_hs && r_last_i && w_rid_ok &&
                           (w_rid_idx == IDX_W'(i)) && (r_cnt[i] != '0);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (!w_inc[i] && w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bad_id <= 1'b0;
        end else if (r_valid_i && !w_rid_ok) begin
            r_bad_id <= 1'b1;
        end
    end

    assign ar_addr_o  = r_addr;
    assign ar_len_o   = r_len;
    assign ar_id_o    = ID_WIDTH'(r_gnt);
    assign rsp_data_o = r_data_i;
    assign rsp_last_o = r_last_i;
    assign rsp_err_o  = (r_resp_i != 2'b00);
    assign bad_id_o   = r_bad_id;

endmodule
`default_nettype wire

// File: tb/tb_iommu_ds_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_iommu_ds_rd_arbiter
// Brief   : Directed plus randomized bench for the read-path arbiter against a
//           transaction-level model of grants, credits and R routing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iommu_ds_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [AW-1:0] ar_addr;
    logic [7:0]    ar_len;
    logic [IW-1:0] ar_id, r_id;
    logic [DW-1:0] r_data, rsp_data;
    logic [1:0]    r_resp;
    logic          rsp_err, rsp_last, bad_id;

    logic [AW-1:0] a_addr [N];
    logic [7:0]    a_len  [N];

    assign req_addr = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
    assign req_len  = {a_len[3], a_len[2], a_len[1], a_len[0]};

    always #5 clk = ~clk;

    iommu_ds_rd_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_len_i(req_len),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .ar_len_o(ar_len), .ar_id_o(ar_id),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_id_i(r_id), .r_data_i(r_data),
        .r_resp_i(r_resp), .r_last_i(r_last),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err), .rsp_last_o(rsp_last), .bad_id_o(bad_id)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model: one pending AR, per-ID credit counts, sticky error.
    int          m_cnt [N];
    int          m_ptr;
    bit          m_pend;
    int          m_gnt;
    logic [AW-1:0] m_addr;
    logic [7:0]  m_len;
    bit          m_bad;

    bit          hs_seen;
    int          hs_id;
    logic        obs_arv, obs_rr, obs_last, obs_err;
    logic [N-1:0] obs_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) m_cnt[j] = 0;
        m_ptr = 0; m_pend = 0; m_gnt = 0; m_addr = '0; m_len = '0; m_bad = 0;
    endtask

    task automatic model_edge();
        int  inc_id, dec_id, idx, rid;
        bit  done;
        inc_id = -1; dec_id = -1; done = 0;
        rid = int'(r_id);
        if (r_valid && rid < N && rsp_ready[rid] && r_last && m_cnt[rid] > 0) dec_id = rid;
        if (r_valid && rid >= N) m_bad = 1;
        if (m_pend) begin
            if (ar_ready) begin
                inc_id = m_gnt;
                m_ptr  = (m_gnt + 1) % N;
                m_pend = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!done && req_valid[idx] && m_cnt[idx] < MO) begin
                    done = 1; m_pend = 1; m_gnt = idx;
                    m_addr = a_addr[idx]; m_len = a_len[idx];
                end
            end
        end
        if (inc_id >= 0) m_cnt[inc_id]++;
        if (dec_id >= 0) m_cnt[dec_id]--;
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_rq, e_rv;
        logic         e_rr;
        int           rid;
        rid  = int'(r_id);
        e_rq = (m_pend && ar_ready) ? N'(1 << m_gnt) : '0;
        e_rv = (r_valid && rid < N) ? N'(1 << rid) : '0;
        e_rr = (rid < N) ? rsp_ready[r_id[1:0]] : 1'b1;
        chk("ar_valid", 64'(ar_valid), 64'(m_pend));
        if (m_pend) begin
            chk("ar_id",   64'(ar_id),   64'(m_gnt));
            chk("ar_addr", ar_addr,      m_addr);
            chk("ar_len",  64'(ar_len),  64'(m_len));
        end
        chk("req_ready", 64'(req_ready), 64'(e_rq));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        chk("r_ready",   64'(r_ready),   64'(e_rr));
        chk("rsp_data",  rsp_data,       r_data);
        chk("rsp_last",  64'(rsp_last),  64'(r_last));
        chk("rsp_err",   64'(rsp_err),   64'(r_resp != 2'b00));
        chk("bad_id",    64'(bad_id),    64'(m_bad));
    endtask

    // Inputs are driven at posedge+1; outputs checked at posedge+2.
    task automatic cycle();
        #1;
        check_outputs();
        hs_seen  = ar_valid && ar_ready;
        hs_id    = int'(ar_id);
        obs_arv  = ar_valid;
        obs_rv   = rsp_valid;
        obs_rr   = r_ready;
        obs_last = rsp_last;
        obs_err  = rsp_err;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; ar_ready = 1'b0; r_valid = 1'b0; r_id = '0; r_data = '0;
        r_resp = 2'b00; r_last = 1'b0; rsp_ready = '0;
        for (int j = 0; j < N; j++) begin a_addr[j] = '0; a_len[j] = '0; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        chk("rst_ar_valid",  64'(ar_valid),  64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_bad_id",    64'(bad_id),    64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5];
        int got, beats, lasts;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;

        // Single requester, 4-beat burst
        do_reset();
        a_addr[1] = 64'h1000; a_len[1] = 8'd3; req_valid = 4'b0010;
        cycle();
        chk("t1_ar_valid", 64'(ar_valid), 64'd1);
        chk("t1_ar_id",    64'(ar_id),    64'd1);
        chk("t1_ar_addr",  ar_addr,       64'h1000);
        chk("t1_ar_len",   64'(ar_len),   64'd3);
        ar_ready = 1'b1;
        cycle();
        chk("t1_hs", 64'(hs_seen), 64'd1);
        req_valid = '0; ar_ready = 1'b0; rsp_ready = 4'hF;
        beats = 0; lasts = 0;
        for (int b = 0; b < 4; b++) begin
            r_valid = 1'b1; r_id = 4'd1; r_data = {$urandom, $urandom}; r_last = (b == 3);
            cycle();
            if (obs_rv == 4'b0010) beats++;
            if (obs_last) lasts = lasts + b + 1;
        end
        r_valid = 1'b0; r_last = 1'b0;
        chk("t1_beats", 64'(beats), 64'd4);
        chk("t1_last_on_4", 64'(lasts), 64'd4);
        cycle();

        // All four requesting, ready always high
        do_reset();
        req_valid = 4'hF; ar_ready = 1'b1;
        for (int j = 0; j < N; j++) a_addr[j] = 64'(j) << 12;
        exp_order = '{0, 1, 2, 3, 0};
        got = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("t2_alt", 64'(obs_arv), 64'(c % 2));
            if (hs_seen && got < 5) begin
                chk("t2_order", 64'(hs_id), 64'(exp_order[got]));
                got++;
            end
        end
        chk("t2_count", 64'(got), 64'd5);

        // Credit limit
        do_reset();
        req_valid = 4'b0100; ar_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin cycle(); if (hs_seen) got++; end
        chk("t3_two_ar", 64'(got), 64'd2);
        r_valid = 1'b1; r_id = 4'd2; r_last = 1'b1; rsp_ready = 4'hF;
        cycle();
        r_valid = 1'b0; r_last = 1'b0;
        got = 0;
        for (int c = 0; c < 6; c++) begin cycle(); if (hs_seen) got++; end
        chk("t3_third_ar", 64'(got), 64'd1);
        req_valid = '0; ar_ready = 1'b0;
        cycle();

        // Interleaved R with requester 3 back-pressuring
        rsp_ready = 4'b0111;
        for (int i = 0; i < 6; i++) begin
            r_valid = 1'b1; r_id = (i % 2 == 1) ? 4'd3 : 4'd0; r_data = {$urandom, $urandom};
            cycle();
            chk("t4_r_ready",  64'(obs_rr),    64'((i % 2 == 1) ? 0 : 1));
            chk("t4_rsp_id0",  64'(obs_rv[0]), 64'((i % 2 == 1) ? 0 : 1));
        end

        // Out-of-range ID and error response
        r_valid = 1'b1; r_id = 4'd7;
        cycle();
        chk("t5_drain",  64'(obs_rr), 64'd1);
        chk("t5_no_rsp", 64'(obs_rv), 64'd0);
        r_valid = 1'b0;
        chk("t5_bad_set", 64'(bad_id), 64'd1);
        cycle(); cycle();
        chk("t5_bad_sticky", 64'(bad_id), 64'd1);
        r_valid = 1'b1; r_id = 4'd0; r_resp = 2'd2; rsp_ready = 4'hF;
        cycle();
        chk("t5_err", 64'(obs_err), 64'd1);
        r_valid = 1'b0; r_resp = 2'd0;
        cycle();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            for (int j = 0; j < N; j++) begin
                a_addr[j] = {$urandom, $urandom};
                a_len[j]  = 8'($urandom);
            end
            ar_ready  = 1'($urandom_range(0, 1));
            r_valid   = 1'($urandom_range(0, 1));
            r_id      = IW'($urandom_range(0, N - 1));
            r_last    = (m_cnt[int'(r_id)] > 0) && ($urandom_range(0, 2) == 0);
            r_resp    = 2'($urandom);
            r_data    = {$urandom, $urandom};
            rsp_ready = N'($urandom);
            cycle();
        end

        // Asynchronous reset while an AR is pending
        do_reset();
        a_addr[1] = 64'h2000; req_valid = 4'b0010; ar_ready = 1'b1;
        cycle(); cycle();
        chk("t6_hs1", 64'(hs_seen), 64'd1);
        ar_ready = 1'b0;
        cycle();
        chk("t6_pending", 64'(ar_valid), 64'd1);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("t6_ar_valid",  64'(ar_valid),  64'd0);
        chk("t6_req_ready", 64'(req_ready), 64'd0);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_bad_id",    64'(bad_id),    64'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'hF; ar_ready = 1'b1;
        cycle(); cycle();
        chk("t6_first_idx0", 64'(hs_id), 64'd0);
        req_valid = 4'b0010;
        got = 0;
        for (int c = 0; c < 8; c++) begin cycle(); if (hs_seen) got++; end
        chk("t6_cnt_cleared", 64'(got), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
